// File: rtl/uart_tx_pkg.sv
// Shared UART definitions, imported by both the RX and TX blocks.
//   - uart_state_e         : frame FSM state encodings
//   - DEFAULT_CLKS_PER_BIT : baud divisor for 115200 baud from a 100 MHz clock
package uart_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last
// cycle of each bit period.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear, holds the count at 0
//   tick - high during the final cycle of a bit period
module uart_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   tx_start     - one-cycle send request (ignored while busy)
//   tx_data      - payload, captured when tx_start is accepted
//   tx           - registered serial line, idle high
//   tx_busy      - high while a frame is in progress
//   tx_done_tick - one-cycle pulse at the end of the last stop bit
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int            BW         = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY_EN != 0);
  localparam logic          ODD        = logic'(PARITY_ODD != 0);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;   // data bit index, reused as stop bit index
  logic                 par_bit;
  logic                 tick;

  // Hold the divider at 0 while idle so the start bit gets a full period
  // counted from the accepting edge.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      par_bit      <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // The done-tick cycle still counts as busy for request purposes.
          if (tx_start && !tx_done_tick) begin
            shreg   <= tx_data;
            bit_cnt <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            // Shift register is still full here: take parity from it.
            par_bit <= (^shreg) ^ ODD;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (HAS_PARITY) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt      <= '0;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8.
// Four instances: 8N1, 8E1, 8O1, 8N2. Outputs sampled on falling edges.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [4];
  logic [7:0] data  [4];
  logic       txs   [4];
  logic       busys [4];
  logic       dones [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data[0]),
    .tx(txs[0]), .tx_busy(busys[0]), .tx_done_tick(dones[0]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data[1]),
    .tx(txs[1]), .tx_busy(busys[1]), .tx_done_tick(dones[1]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data[2]),
    .tx(txs[2]), .tx_busy(busys[2]), .tx_done_tick(dones[2]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(data[3]),
    .tx(txs[3]), .tx_busy(busys[3]), .tx_done_tick(dones[3]));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Request a frame on instance i; returns at the falling edge right after
  // the accepting rising edge, with tx_data already scrambled.
  task automatic launch(input int i, input logic [7:0] d);
    @(negedge clk);
    start[i] = 1'b1;
    data[i]  = d;
    @(negedge clk);
    start[i] = 1'b0;
    data[i]  = ~d;
  endtask

  // Entered at cycle 0 of a frame. exp holds the expected line bits in
  // transmit order (bit 0 = start bit); len is the frame length in clocks.
  task automatic check_frame(input int i, input logic [15:0] exp, input int len, input string tag);
    logic early = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k % CPB == 2) begin
        chk({tag, "_bit"}, 16'(txs[i]), 16'(exp[k / CPB]));
        chk({tag, "_busy"}, 16'(busys[i]), 16'd1);
      end
      if (dones[i]) early = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_done"}, 16'(dones[i]), 16'd1);
    chk({tag, "_idle_busy"}, 16'(busys[i]), 16'd0);
    chk({tag, "_idle_tx"}, 16'(txs[i]), 16'd1);
    chk({tag, "_early_done"}, 16'(early), 16'd0);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      data[i]  = 8'h00;
    end

    // Reset held 3 cycles, then released; line stays idle.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 16'(txs[0]), 16'd1);
      chk("rst_busy", 16'(busys[0]), 16'd0);
      chk("rst_done", 16'(dones[0]), 16'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk("post_rst_tx", 16'(txs[i]), 16'd1);
        chk("post_rst_busy", 16'(busys[i]), 16'd0);
        chk("post_rst_done", 16'(dones[i]), 16'd0);
      end
    end

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1 ; done 40 cycles after acceptance.
    launch(0, 8'hA5);
    check_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 40, "8n1_a5");
    @(negedge clk);
    chk("8n1_done_pulse", 16'(dones[0]), 16'd0);

    // Even parity of 0xA5 (four ones) is 0; odd is 1. 44 cycles.
    launch(1, 8'hA5);
    check_frame(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 44, "8e1_a5");
    launch(2, 8'hA5);
    check_frame(2, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 44, "8o1_a5");

    // Two stop bits, 0x00: 8 high cycles after the last data bit, done at 44.
    launch(3, 8'h00);
    check_frame(3, 16'({2'b11, 8'h00, 1'b0}), 44, "8n2_00");
    @(negedge clk);
    chk("8n2_done_pulse", 16'(dones[3]), 16'd0);

    // Back-to-back: tx_start held high, data switches to 0xFF mid-frame.
    @(negedge clk);
    start[0] = 1'b1;
    data[0]  = 8'h00;
    @(negedge clk);
    data[0]  = 8'hFF;
    check_frame(0, 16'({1'b1, 8'h00, 1'b0}), 40, "b2b_first");
    @(negedge clk);   // done-tick cycle: request ignored
    chk("b2b_gap_tx", 16'(txs[0]), 16'd1);
    chk("b2b_gap_busy", 16'(busys[0]), 16'd0);
    chk("b2b_gap_done", 16'(dones[0]), 16'd0);
    @(negedge clk);   // accepted on the following edge
    start[0] = 1'b0;
    chk("b2b_second_start", 16'(txs[0]), 16'd0);
    check_frame(0, 16'({1'b1, 8'hFF, 1'b0}), 40, "b2b_second");

    // Abort: reset in cycle 17 of a 0x3C frame.
    launch(0, 8'h3C);
    repeat (17) @(negedge clk);
    chk("abort_pre_busy", 16'(busys[0]), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", 16'(txs[0]), 16'd1);
    chk("abort_busy", 16'(busys[0]), 16'd0);
    chk("abort_done", 16'(dones[0]), 16'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (dones[0] || !txs[0] || busys[0]) seen = 1'b1;
    end
    chk("abort_quiet", 16'(seen), 16'd0);

    // Fresh 0x3C accepted on the very first edge after reset release.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    start[0] = 1'b1;
    data[0]  = 8'h3C;
    @(negedge clk);
    start[0] = 1'b0;
    data[0]  = 8'hC3;
    chk("rel_accept_tx", 16'(txs[0]), 16'd0);
    check_frame(0, 16'({1'b1, 8'h3C, 1'b0}), 40, "rel_3c");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
